cfu_cmd_initiator: RTL and testbench
====================================

Name: cfu_cmd_initiator

Overview:
Initiator (CPU-side) end of the CFU custom-instruction handshake. It queues requests of the form (function_id, inputs_0, inputs_1) from an upstream master such as a DMA or test sequencer. It issues them one at a time on the cmd_* channel, collects rsp_payload_outputs_0 into a result queue, and guards each transaction with a response timeout. It lets layer kernels drive the Cfu accelerator (SIMD MAC, quantized multiply, exp, reciprocal) without CPU involvement.

Parameters:
CMD_DEPTH, 4, request FIFO entries (power of 2, >=2)
RES_DEPTH, 4, result FIFO entries (power of 2, >=2)
TIMEOUT, 1024, max cycles in WAIT_RSP before abort; 0 disables timeout
TIMEOUT_WORD, 32'hDEADBEEF, data pushed to the result FIFO on timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  upstream request valid
req_ready  out  1  request FIFO not full
req_function_id  in  10  function id
req_inputs_0  in  32  operand 0
req_inputs_1  in  32  operand 1
cmd_valid  out  1  to CFU
cmd_ready  in  1  from CFU
cmd_payload_function_id  out  10  registered
cmd_payload_inputs_0  out  32  registered
cmd_payload_inputs_1  out  32  registered
rsp_valid  in  1  from CFU
rsp_ready  out  1  to CFU
rsp_payload_outputs_0  in  32  CFU result
res_valid  out  1  result FIFO not empty
res_ready  in  1  downstream pop
res_data  out  32  head result
res_timeout  out  1  head entry produced by timeout
err_timeout  out  1  sticky timeout flag
err_clear  in  1  clears err_timeout
issued_count  out  16  completed CFU command handshakes, wraps at 2^16
busy  out  1  state!=IDLE or request FIFO non-empty or stale_pending

Behaviour:
- Reset: FIFOs empty; state=IDLE; cmd_valid=0; rsp_ready=0; all cmd_payload_*=0; res_valid=0; err_timeout=0; issued_count=0; stale_pending=0; timer=0.
- Handshakes fire when valid&ready are both high at a clk edge.
- req_ready = !cmd_fifo_full. res_valid = !res_fifo_empty. res_data and res_timeout come from the FIFO head (first-word fall-through).
- Ordering is strict FIFO. At most one CFU command is outstanding.
- State IDLE:
  - Condition to issue: cmd FIFO non-empty, res FIFO not full, and stale_pending=0.
  - When the condition holds: pop the request into the cmd_payload registers, set cmd_valid=1, go to ISSUE.
  - Latency: a request pushed at edge N into an empty FIFO in IDLE gives cmd_valid=1 in the cycle after edge N+1.
- State ISSUE:
  - cmd_valid and payload are held stable until cmd_ready.
  - On handshake: cmd_valid=0, issued_count+1, timer=0, go to WAIT_RSP.
- State WAIT_RSP:
  - rsp_ready=1 (registered high on entry).
  - On rsp handshake: push {rsp_payload_outputs_0, timeout=0}, rsp_ready=0, go to IDLE. res_valid rises the cycle after the rsp edge if the FIFO was empty.
  - Otherwise timer+1.
  - If TIMEOUT!=0 and timer==TIMEOUT-1 with no rsp: push {TIMEOUT_WORD, 1}, set err_timeout=1 and stale_pending=1, go to IDLE.
- Stale response:
  - While stale_pending=1, rsp_ready=1 outside WAIT_RSP.
  - The next rsp handshake is discarded (no push) and clears stale_pending.
  - No issue occurs while stale_pending=1.
- Result space: the IDLE gate guarantees a free result slot for either push; no result is ever dropped.
- Simultaneous events:
  - res pop and push in the same cycle are both honoured.
  - req push and pop in the same cycle when full: req_ready reflects the pre-pop state, so no push is accepted.
  - err_clear together with a new timeout: set wins.
- Reset mid-operation: everything returns to reset values at the next edge; in-flight CFU state is not tracked (the CFU shares reset).
- Widths: FIFO pointers carry an extra wrap bit (full = MSB differs, rest equal); timer is clog2(TIMEOUT)+1 bits.

Test Plan:
1. Basic MAC: push {fid=10'h008, in0=32'h01020304, in1=32'h01010101}; bench CFU answers 3 cycles after cmd handshake with 32'h0000000A. Required: cmd_valid 2 cycles after the req edge; res_data=32'h0000000A, res_timeout=0, issued_count=1.
2. Cmd backpressure: cmd_ready low 5 cycles. Required: cmd_valid and payload stable throughout; exactly one handshake; issued_count=1.
3. Queue fill: cmd_ready=0, push 6 requests with CMD_DEPTH=4. Required: 1 held in ISSUE, 4 queued, req_ready=0 at the 6th. After release, results appear in push order.
4. Result full: res_ready=0, 5 requests, RES_DEPTH=4. Required: 4 results queued and no 5th cmd_valid. One pop lets the 5th issue; its result lands last.
5. Timeout: TIMEOUT=16, CFU silent. Required: on the 16th WAIT_RSP cycle, res_data=32'hDEADBEEF, res_timeout=1, err_timeout=1. A late rsp 32'h12345678 at +4 cycles is discarded. The next request completes correctly. err_clear then gives err_timeout=0.
6. Reset in WAIT_RSP with 2 queued requests and 1 result queued. Required: next cycle res_valid=0, cmd_valid=0, rsp_ready=0, req_ready=1, issued_count=0, busy=0.

Source files
------------

// File: rtl/cfu_cmd_initiator.sv
// CPU-side initiator for the CFU custom-instruction handshake: queues requests, issues one
// command at a time, collects responses into a result queue and aborts on response timeout.
module cfu_cmd_initiator #(
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned RES_DEPTH    = 4,
  parameter int unsigned TIMEOUT      = 1024,
  parameter logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [9:0]  req_function_id_i,
  input  logic [31:0] req_inputs_0_i,
  input  logic [31:0] req_inputs_1_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [9:0]  cmd_payload_function_id_o,
  output logic [31:0] cmd_payload_inputs_0_o,
  output logic [31:0] cmd_payload_inputs_1_o,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic [31:0] rsp_payload_outputs_0_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  output logic        res_timeout_o,
  output logic        err_timeout_o,
  input  logic        err_clear_i,
  output logic [15:0] issued_count_o,
  output logic        busy_o
);

  localparam int unsigned CmdAw  = $clog2(CMD_DEPTH);
  localparam int unsigned ResAw  = $clog2(RES_DEPTH);
  localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

  state_e             state_q, state_d;
  logic [73:0]        cmd_mem_q [CMD_DEPTH];
  logic [CmdAw:0]     cmd_wptr_q, cmd_rptr_q;
  logic [32:0]        res_mem_q [RES_DEPTH];
  logic [ResAw:0]     res_wptr_q, res_rptr_q;
  logic               cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic               res_full, res_empty, res_push, res_pop;
  logic [32:0]        res_push_data;
  logic [73:0]        cmd_head;
  logic               cmd_valid_q, cmd_valid_d;
  logic [9:0]         fid_q, fid_d;
  logic [31:0]        in0_q, in0_d, in1_q, in1_d;
  logic               rsp_ready_q, rsp_ready_d;
  logic               stale_q, stale_d;
  logic               err_q, err_d;
  logic [15:0]        count_q, count_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               cmd_hs, rsp_hs, timeout_hit;

  // Pointers carry a wrap bit: full when the wrap bits differ and the indices match.
  assign cmd_full  = (cmd_wptr_q[CmdAw] != cmd_rptr_q[CmdAw]) &&
                     (cmd_wptr_q[CmdAw-1:0] == cmd_rptr_q[CmdAw-1:0]);
  assign cmd_empty = (cmd_wptr_q == cmd_rptr_q);
  assign res_full  = (res_wptr_q[ResAw] != res_rptr_q[ResAw]) &&
                     (res_wptr_q[ResAw-1:0] == res_rptr_q[ResAw-1:0]);
  assign res_empty = (res_wptr_q == res_rptr_q);

  assign req_ready_o = !cmd_full;
  assign cmd_push    = req_valid_i && req_ready_o;
  assign cmd_head    = cmd_mem_q[cmd_rptr_q[CmdAw-1:0]];
  assign res_valid_o = !res_empty;
  assign res_pop     = res_valid_o && res_ready_i;
  assign {res_data_o, res_timeout_o} = res_mem_q[res_rptr_q[ResAw-1:0]];

  assign cmd_valid_o               = cmd_valid_q;
  assign cmd_payload_function_id_o = fid_q;
  assign cmd_payload_inputs_0_o    = in0_q;
  assign cmd_payload_inputs_1_o    = in1_q;
  // Outside WAIT_RSP the only reason to accept a response is to drain a stale one.
  assign rsp_ready_o    = rsp_ready_q || stale_q;
  assign err_timeout_o  = err_q;
  assign issued_count_o = count_q;
  assign busy_o         = (state_q != StIdle) || !cmd_empty || stale_q;

  assign cmd_hs      = cmd_valid_q && cmd_ready_i;
  assign rsp_hs      = rsp_valid_i && rsp_ready_o;
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TimerW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    cmd_valid_d   = cmd_valid_q;
    fid_d         = fid_q;
    in0_d         = in0_q;
    in1_d         = in1_q;
    rsp_ready_d   = rsp_ready_q;
    stale_d       = stale_q;
    err_d         = err_q;
    count_d       = count_q;
    timer_d       = timer_q;
    cmd_pop       = 1'b0;
    res_push      = 1'b0;
    res_push_data = '0;
    if (err_clear_i) err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (stale_q && rsp_hs) stale_d = 1'b0;
        if (!cmd_empty && !res_full && !stale_q) begin
          cmd_pop               = 1'b1;
          {fid_d, in0_d, in1_d} = cmd_head;
          cmd_valid_d           = 1'b1;
          state_d               = StIssue;
        end
      end
      StIssue: begin
        if (cmd_hs) begin
          cmd_valid_d = 1'b0;
          count_d     = count_q + 16'd1;
          timer_d     = '0;
          rsp_ready_d = 1'b1;
          state_d     = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (rsp_hs) begin
          res_push      = 1'b1;
          res_push_data = {rsp_payload_outputs_0_i, 1'b0};
          rsp_ready_d   = 1'b0;
          state_d       = StIdle;
        end else if (timeout_hit) begin
          res_push      = 1'b1;
          res_push_data = {TIMEOUT_WORD, 1'b1};
          err_d         = 1'b1;
          stale_d       = 1'b1;
          rsp_ready_d   = 1'b0;
          state_d       = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      fid_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      rsp_ready_q <= 1'b0;
      stale_q     <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      timer_q     <= '0;
      cmd_wptr_q  <= '0;
      cmd_rptr_q  <= '0;
      res_wptr_q  <= '0;
      res_rptr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      fid_q       <= fid_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      rsp_ready_q <= rsp_ready_d;
      stale_q     <= stale_d;
      err_q       <= err_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + (CmdAw + 1)'(1);
      if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + (CmdAw + 1)'(1);
      if (res_push) res_wptr_q <= res_wptr_q + (ResAw + 1)'(1);
      if (res_pop)  res_rptr_q <= res_rptr_q + (ResAw + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_push) cmd_mem_q[cmd_wptr_q[CmdAw-1:0]] <=
        {req_function_id_i, req_inputs_0_i, req_inputs_1_i};
    if (res_push) res_mem_q[res_wptr_q[ResAw-1:0]] <= res_push_data;
  end

endmodule

// File: tb/tb_cfu_cmd_initiator.sv
// Directed bench for cfu_cmd_initiator: table of single transactions plus hand-written
// sequences for backpressure, queue fill, result-full stall, timeout and reset.
module tb_cfu_cmd_initiator;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [9:0]  req_fid, cmd_fid;
  logic [31:0] req_in0, req_in1, cmd_in0, cmd_in1, rsp_data, res_data;
  logic        res_valid, res_ready, res_timeout, err_timeout, err_clear, busy;
  logic [15:0] issued_count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  cfu_cmd_initiator #(
    .CMD_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(16), .TIMEOUT_WORD(32'hDEADBEEF)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_function_id_i(req_fid),
    .req_inputs_0_i(req_in0), .req_inputs_1_i(req_in1),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_payload_function_id_o(cmd_fid), .cmd_payload_inputs_0_o(cmd_in0),
    .cmd_payload_inputs_1_o(cmd_in1),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_payload_outputs_0_i(rsp_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_timeout_o(res_timeout), .err_timeout_o(err_timeout), .err_clear_i(err_clear),
    .issued_count_o(issued_count), .busy_o(busy)
  );

  typedef struct {
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    int          delay;
    logic [31:0] rsp;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_fid   = fid;
    req_in0   = a;
    req_in1   = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic handshake_cmd(input logic [9:0] fid);
    for (int t = 0; t < 20 && !cmd_valid; t++) tick();
    chk("cmd_valid_wait", 32'(cmd_valid), 32'd1);
    chk("cmd_fid", 32'(cmd_fid), 32'(fid));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    exp_count++;
    chk("issued_count", 32'(issued_count), 32'(exp_count));
    chk("rsp_ready_wait", 32'(rsp_ready), 32'd1);
  endtask

  task automatic serve(input logic [9:0] fid, input logic [31:0] d);
    handshake_cmd(fid);
    rsp_valid = 1'b1;
    rsp_data  = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic pop();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{10'h008, 32'h01020304, 32'h01010101, 3, 32'h0000000A, 32'h0000000A};
    vecs[1] = '{10'h3FF, 32'hFFFFFFFF, 32'h00000000, 1, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[2] = '{10'h001, 32'h80000000, 32'h7FFFFFFF, 5, 32'h00000000, 32'h00000000};
    vecs[3] = '{10'h155, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 32'h12345678, 32'h12345678};

    reset = 1'b1; req_valid = 1'b0; req_fid = '0; req_in0 = '0; req_in1 = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; res_ready = 1'b0; err_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_payload", cmd_in0 | cmd_in1 | 32'(cmd_fid), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_count", 32'(issued_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Table: single transactions with exact issue latency and response delay.
    for (int i = 0; i < 4; i++) begin
      push_req(vecs[i].fid, vecs[i].in0, vecs[i].in1);
      chk("vec_cmd_valid_early", 32'(cmd_valid), 32'd0);
      tick();
      chk("vec_cmd_valid", 32'(cmd_valid), 32'd1);
      chk("vec_fid", 32'(cmd_fid), 32'(vecs[i].fid));
      chk("vec_in0", cmd_in0, vecs[i].in0);
      chk("vec_in1", cmd_in1, vecs[i].in1);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      exp_count++;
      chk("vec_cmd_drop", 32'(cmd_valid), 32'd0);
      chk("vec_count", 32'(issued_count), 32'(exp_count));
      for (int d = 1; d < vecs[i].delay; d++) tick();
      chk("vec_res_not_yet", 32'(res_valid), 32'd0);
      rsp_valid = 1'b1;
      rsp_data  = vecs[i].rsp;
      tick();
      rsp_valid = 1'b0;
      chk("vec_res_valid", 32'(res_valid), 32'd1);
      chk("vec_res_data", res_data, vecs[i].exp_res);
      chk("vec_res_timeout", 32'(res_timeout), 32'd0);
      chk("vec_rsp_ready_low", 32'(rsp_ready), 32'd0);
      pop();
      chk("vec_res_popped", 32'(res_valid), 32'd0);
    end

    // Command backpressure: payload held stable, exactly one handshake.
    push_req(10'h02A, 32'h11111111, 32'h22222222);
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_cmd_valid", 32'(cmd_valid), 32'd1);
      chk("bp_in0", cmd_in0, 32'h11111111);
      chk("bp_count", 32'(issued_count), 32'(exp_count));
    end
    serve(10'h02A, 32'h0000BEEF);
    chk("bp_cmd_drop", 32'(cmd_valid), 32'd0);
    chk("bp_res", res_data, 32'h0000BEEF);
    pop();

    // Queue fill: one held in ISSUE, four queued, sixth refused.
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1;
      req_fid   = 10'(16 + k);
      req_in0   = 32'(k);
      req_in1   = 32'(k);
      chk("fill_req_ready", 32'(req_ready), (k < 5) ? 32'd1 : 32'd0);
      tick();
    end
    req_valid = 1'b0;
    chk("fill_full", 32'(req_ready), 32'd0);
    chk("fill_hold_fid", 32'(cmd_fid), 32'd16);
    for (int k = 0; k < 5; k++) begin
      serve(10'(16 + k), 32'h100 + 32'(k));
      chk("fill_order", res_data, 32'h100 + 32'(k));
      pop();
    end
    chk("fill_empty", 32'(res_valid), 32'd0);

    // Result FIFO full blocks the fifth issue until one pop.
    for (int k = 0; k < 5; k++) push_req(10'(32 + k), 32'(k), 32'(k));
    for (int k = 0; k < 4; k++) serve(10'(32 + k), 32'h200 + 32'(k));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rfull_no_issue", 32'(cmd_valid), 32'd0);
    end
    chk("rfull_busy", 32'(busy), 32'd1);
    chk("rfull_head", res_data, 32'h200);
    pop();
    serve(10'd36, 32'h204);
    for (int k = 1; k < 5; k++) begin
      chk("rfull_order", res_data, 32'h200 + 32'(k));
      pop();
    end
    chk("rfull_empty", 32'(res_valid), 32'd0);

    // Timeout, stale response discard, recovery, err_clear.
    push_req(10'h077, 32'h1, 32'h2);
    handshake_cmd(10'h077);
    for (int c = 0; c < 15; c++) tick();
    chk("to_not_yet", 32'(res_valid), 32'd0);
    chk("to_err_not_yet", 32'(err_timeout), 32'd0);
    tick();
    chk("to_res_valid", 32'(res_valid), 32'd1);
    chk("to_res_data", res_data, 32'hDEADBEEF);
    chk("to_res_timeout", 32'(res_timeout), 32'd1);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_stale_ready", 32'(rsp_ready), 32'd1);
    push_req(10'h078, 32'h3, 32'h4);
    tick(); tick();
    chk("to_no_issue_stale", 32'(cmd_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = 32'h12345678;
    tick();
    rsp_valid = 1'b0;
    chk("to_stale_cleared", 32'(rsp_ready), 32'd0);
    chk("to_stale_dropped", res_data, 32'hDEADBEEF);
    pop();
    chk("to_no_stale_push", 32'(res_valid), 32'd0);
    serve(10'h078, 32'h0BADF00D);
    chk("to_recover_data", res_data, 32'h0BADF00D);
    chk("to_recover_flag", 32'(res_timeout), 32'd0);
    pop();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("to_err_clear", 32'(err_timeout), 32'd0);

    // New timeout coinciding with err_clear: set wins.
    push_req(10'h079, 32'h5, 32'h6);
    handshake_cmd(10'h079);
    err_clear = 1'b1;
    for (int c = 0; c < 16; c++) tick();
    err_clear = 1'b0;
    chk("setwins_err", 32'(err_timeout), 32'd1);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    pop();
    chk("setwins_drained", 32'(busy), 32'd0);

    // Reset while waiting for a response with requests and a result queued.
    push_req(10'h0A0, 32'h7, 32'h8);
    serve(10'h0A0, 32'hAAAA5555);
    push_req(10'h0A1, 32'h9, 32'h9);
    push_req(10'h0A2, 32'h9, 32'h9);
    push_req(10'h0A3, 32'h9, 32'h9);
    handshake_cmd(10'h0A1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_res_valid", 32'(res_valid), 32'd0);
    chk("mrst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("mrst_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("mrst_req_ready", 32'(req_ready), 32'd1);
    chk("mrst_count", 32'(issued_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
